// File: rtl/imm_extender_if.sv
// Handshake bundle for imm_extender: upstream immediate/mode in, extended result out.
interface imm_extender_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] ext_out;

  modport slave (
    input  in_valid, imm, mode, out_ready,
    output in_ready, out_valid, ext_out
  );

  modport master (
    output in_valid, imm, mode, out_ready,
    input  in_ready, out_valid, ext_out
  );
endinterface

// File: rtl/imm_extender.sv
// Immediate extender with a registered two-entry (main + skid) output buffer.
// Optional transfer counter port enabled by macro IMM_EXTENDER_XFER_CNT_EN.
module imm_extender #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned BR_SH = 2
) (
  input logic           clk,
  input logic           rst,
  imm_extender_if.slave bus
`ifdef IMM_EXTENDER_XFER_CNT_EN
  ,
  output logic [15:0]   xfer_cnt
`endif
);

  if (OUT_W < IN_W + BR_SH) begin : g_width_check
    $error("imm_extender: OUT_W must be >= IN_W + BR_SH");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] main_q, skid_q;
  logic [OUT_W-1:0] ext_d;
  logic             in_ready_q, out_valid_q;
  logic             push, pop;
  logic             load_main, load_skid, main_from_skid;
  logic [IN_W-1:0]  imm_s;

  assign imm_s = bus.imm;
  assign push  = bus.in_valid && in_ready_q;
  assign pop   = out_valid_q && bus.out_ready;

  always_comb begin
    ext_d = '0;
    unique case (bus.mode)
      2'b00: ext_d = OUT_W'($signed(imm_s));
      2'b01: ext_d = OUT_W'(imm_s);
      2'b10: ext_d = OUT_W'($signed(imm_s)) << BR_SH;
      2'b11: ext_d = OUT_W'(imm_s) << (OUT_W - IN_W);
      default: ext_d = '0;
    endcase
  end

  // Flags are registered from the next state so they are valid the cycle the state is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (load_main) main_q <= main_from_skid ? skid_q : ext_d;
      if (load_skid) skid_q <= ext_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: load_main = push;
      ONE: begin
        load_main = push && pop;
        load_skid = push && !pop;
      end
      FULL: begin
        load_main      = pop;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ext_out   = main_q;

`ifdef IMM_EXTENDER_XFER_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 16'd1;
  end
  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_extender.sv
// Directed self-checking bench for imm_extender with hand-computed expectations.
module tb_imm_extender;
  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  imm_extender_if #(.IN_W(16), .OUT_W(32)) bus ();

`ifdef IMM_EXTENDER_XFER_CNT_EN
  logic [15:0] xfer_cnt;
  imm_extender #(.IN_W(16), .OUT_W(32), .BR_SH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .xfer_cnt(xfer_cnt)
  );
`else
  imm_extender #(.IN_W(16), .OUT_W(32), .BR_SH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v, input logic [1:0] m);
    bus.in_valid = 1'b1;
    bus.imm      = v;
    bus.mode     = m;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.imm       = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_ext_out",   bus.ext_out,        32'h0);

    // four modes on 0x8001, draining every cycle
    bus.out_ready = 1'b1;
    push(16'h8001, 2'b00); step();
    chk("m00_valid", 32'(bus.out_valid), 32'd1);
    chk("m00", bus.ext_out, 32'hFFFF8001);
    push(16'h8001, 2'b01); step();
    chk("m01", bus.ext_out, 32'h00008001);
    push(16'h8001, 2'b10); step();
    chk("m10", bus.ext_out, 32'hFFFE0004);
    push(16'h8001, 2'b11); step();
    chk("m11", bus.ext_out, 32'h80010000);
    chk("m11_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0; step();
    chk("drain_valid", 32'(bus.out_valid), 32'd0);

    // backpressure: third push must be dropped
    bus.out_ready = 1'b0;
    push(16'h0001, 2'b01); step();
    chk("bp1_ready", 32'(bus.in_ready), 32'd1);
    push(16'h0002, 2'b01); step();
    chk("bp2_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2_out", bus.ext_out, 32'h00000001);
    push(16'h0003, 2'b01); step();
    chk("bp3_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3_stable", bus.ext_out, 32'h00000001);
    chk("bp3_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; step();
    chk("bp_pop1_out", bus.ext_out, 32'h00000002);
    chk("bp_pop1_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_pop1_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("bp_pop2_valid", 32'(bus.out_valid), 32'd0);

    // FULL with push+pop on same edge: pop only
    bus.out_ready = 1'b0;
    push(16'h0010, 2'b01); step();
    push(16'h0020, 2'b01); step();
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    push(16'h0030, 2'b01); bus.out_ready = 1'b1; step();
    chk("full_pp_out", bus.ext_out, 32'h00000020);
    chk("full_pp_ready", 32'(bus.in_ready), 32'd1);
    chk("full_pp_valid", 32'(bus.out_valid), 32'd1);

    // ONE with push+pop: replace main, stay ONE
    push(16'h7FFF, 2'b10); step();
    chk("one_pp_out", bus.ext_out, 32'h0001FFFC);
    chk("one_pp_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0; step();
    chk("one_pp_drain", 32'(bus.out_valid), 32'd0);

    // back-to-back throughput in FIFO order
    push(16'hFFFF, 2'b11); step();
    chk("tp1", bus.ext_out, 32'hFFFF0000);
    push(16'h7FFF, 2'b00); step();
    chk("tp2", bus.ext_out, 32'h00007FFF);
    push(16'hFFFF, 2'b01); step();
    chk("tp3", bus.ext_out, 32'h0000FFFF);
    bus.in_valid = 1'b0; step();

    // reset from FULL, with a push pending during reset
    bus.out_ready = 1'b0;
    push(16'h0005, 2'b01); step();
    push(16'h0006, 2'b01); step();
    chk("pre_rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1; push(16'h0007, 2'b01); bus.out_ready = 1'b1; step();
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("rst2_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_ready", 32'(bus.in_ready), 32'd1);
    chk("rst2_out", bus.ext_out, 32'h0);
`ifdef IMM_EXTENDER_XFER_CNT_EN
    chk("rst2_cnt", 32'(xfer_cnt), 32'd0);
`endif
    push(16'hFFFF, 2'b00); step();
    chk("post_rst_out", bus.ext_out, 32'hFFFFFFFF);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0; step();

`ifdef IMM_EXTENDER_XFER_CNT_EN
    rst = 1'b1; step(); rst = 1'b0;
    bus.out_ready = 1'b1;
    push(16'h0001, 2'b01);
    for (int unsigned i = 0; i < 65537; i++) step();
    bus.in_valid = 1'b0; step();
    chk("cnt_wrap", 32'(xfer_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
